// File: rtl/lobster_cache_arb_if.sv
// Request, range-invalidate and cache-side signals of the lobster_cache front-end arbiter.
// slave is the arbiter's view; master is the view of the requesters, invalidate source and cache.
interface lobster_cache_arb_if #(
    parameter int unsigned ADDR_WIDTH = 36,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  rq0_valid;
    logic                  rq0_ready;
    logic                  rq0_we;
    logic [ADDR_WIDTH-1:0] rq0_addr;
    logic [DATA_WIDTH-1:0] rq0_wdata;
    logic                  rq0_rvalid;
    logic [DATA_WIDTH-1:0] rq0_rdata;

    logic                  rq1_valid;
    logic                  rq1_ready;
    logic                  rq1_we;
    logic [ADDR_WIDTH-1:0] rq1_addr;
    logic [DATA_WIDTH-1:0] rq1_wdata;
    logic                  rq1_rvalid;
    logic [DATA_WIDTH-1:0] rq1_rdata;

    logic                  inv_start;
    logic [ADDR_WIDTH-1:0] inv_base;
    logic [CNT_WIDTH-1:0]  inv_count;
    logic                  inv_busy;
    logic                  inv_done;

    logic                  c_we;
    logic                  c_inv;
    logic [ADDR_WIDTH-1:0] c_addr_in;
    logic [ADDR_WIDTH-1:0] c_addr_out;
    logic [DATA_WIDTH-1:0] c_data_in;
    logic [DATA_WIDTH-1:0] c_data_out;

    modport slave (
        input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        output rq0_ready, rq0_rvalid, rq0_rdata,
        input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        output rq1_ready, rq1_rvalid, rq1_rdata,
        input  inv_start, inv_base, inv_count,
        output inv_busy, inv_done,
        output c_we, c_inv, c_addr_in, c_addr_out, c_data_in,
        input  c_data_out
    );

    modport master (
        output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        input  rq0_ready, rq0_rvalid, rq0_rdata,
        output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        input  rq1_ready, rq1_rvalid, rq1_rdata,
        output inv_start, inv_base, inv_count,
        input  inv_busy, inv_done,
        input  c_we, c_inv, c_addr_in, c_addr_out, c_data_in,
        output c_data_out
    );
endinterface

// File: rtl/lobster_cache_arb.sv
// Front-end controller for the lobster_cache data array: round-robin arbitration of two
// requesters onto the cache ports, plus a one-word-per-cycle range-invalidate sequencer.
module lobster_cache_arb #(
    parameter int unsigned ADDR_WIDTH = 36,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst,
    lobster_cache_arb_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e                r_state, w_state_d;
    logic                  r_pend, w_pend_d;
    logic                  r_last, w_last_d;  // 1: rq1 was granted most recently
    logic [ADDR_WIDTH-1:0] r_cur, w_cur_d;
    logic [CNT_WIDTH-1:0]  r_rem, w_rem_d;
    logic                  r_done, w_done_d;

    logic                  r_iss_v;
    logic                  r_iss_we;
    logic                  r_iss_id;
    logic [ADDR_WIDTH-1:0] r_iss_addr;
    logic [DATA_WIDTH-1:0] r_iss_wdata;

    logic                  r_rv0, r_rv1;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

    logic                  w_can_grant;
    logic                  w_inv_take;
    logic                  w_gnt0, w_gnt1, w_acc;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_rd_done;

    always_comb begin
        w_inv_take  = (r_state == StIdle) && !r_pend && bus.inv_start;
        w_can_grant = (r_state == StIdle) && !r_pend && !bus.inv_start && !rst;
        w_gnt0      = w_can_grant && bus.rq0_valid && (!bus.rq1_valid || r_last);
        w_gnt1      = w_can_grant && bus.rq1_valid && (!bus.rq0_valid || !r_last);
        w_acc       = w_gnt0 || w_gnt1;
        w_sel_we    = w_gnt1 ? bus.rq1_we    : bus.rq0_we;
        w_sel_addr  = w_gnt1 ? bus.rq1_addr  : bus.rq0_addr;
        w_sel_wdata = w_gnt1 ? bus.rq1_wdata : bus.rq0_wdata;
        w_rd_done   = r_iss_v && !r_iss_we;
    end

    // Next-state: taking inv_start blocks grants that cycle, so the issue register is
    // always empty the following cycle and the sweep can start immediately.
    always_comb begin
        w_state_d = r_state;
        w_pend_d  = r_pend;
        w_cur_d   = r_cur;
        w_rem_d   = r_rem;
        w_done_d  = 1'b0;
        w_last_d  = r_last;
        if (w_gnt0) begin
            w_last_d = 1'b0;
        end else if (w_gnt1) begin
            w_last_d = 1'b1;
        end
        unique case (r_state)
            StIdle: begin
                if (w_inv_take) begin
                    w_cur_d = bus.inv_base;
                    w_rem_d = bus.inv_count;
                    if (bus.inv_count == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_pend_d  = 1'b1;
                        w_state_d = StSweep;
                    end
                end
            end
            StSweep: begin
                w_cur_d = r_cur + WordBytes;
                w_rem_d = r_rem - CNT_WIDTH'(1);
                if (r_rem == CNT_WIDTH'(1)) begin
                    w_state_d = StIdle;
                    w_pend_d  = 1'b0;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.c_we       = 1'b0;
        bus.c_inv      = 1'b0;
        bus.c_addr_in  = '0;
        bus.c_addr_out = '0;
        bus.c_data_in  = '0;
        if (r_iss_v) begin
            // Reads also drive addr_in: the cache validity lookup is keyed on it.
            bus.c_addr_in = r_iss_addr;
            if (r_iss_we) begin
                bus.c_we      = 1'b1;
                bus.c_data_in = r_iss_wdata;
            end else begin
                bus.c_addr_out = r_iss_addr;
            end
        end else if (r_state == StSweep) begin
            bus.c_inv     = 1'b1;
            bus.c_addr_in = r_cur;
        end
    end

    assign bus.rq0_ready  = w_gnt0;
    assign bus.rq1_ready  = w_gnt1;
    assign bus.rq0_rvalid = r_rv0;
    assign bus.rq1_rvalid = r_rv1;
    assign bus.rq0_rdata  = r_rdata0;
    assign bus.rq1_rdata  = r_rdata1;
    assign bus.inv_busy   = r_pend || (r_state == StSweep);
    assign bus.inv_done   = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_pend      <= 1'b0;
            r_last      <= 1'b1;
            r_cur       <= '0;
            r_rem       <= '0;
            r_done      <= 1'b0;
            r_iss_v     <= 1'b0;
            r_iss_we    <= 1'b0;
            r_iss_id    <= 1'b0;
            r_iss_addr  <= '0;
            r_iss_wdata <= '0;
            r_rv0       <= 1'b0;
            r_rv1       <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_d;
            r_last  <= w_last_d;
            r_cur   <= w_cur_d;
            r_rem   <= w_rem_d;
            r_done  <= w_done_d;
            r_iss_v <= w_acc;
            if (w_acc) begin
                r_iss_we    <= w_sel_we;
                r_iss_id    <= w_gnt1;
                r_iss_addr  <= w_sel_addr;
                r_iss_wdata <= w_sel_wdata;
            end
            r_rv0 <= w_rd_done && !r_iss_id;
            r_rv1 <= w_rd_done && r_iss_id;
            if (w_rd_done && !r_iss_id) begin
                r_rdata0 <= bus.c_data_out;
            end
            if (w_rd_done && r_iss_id) begin
                r_rdata1 <= bus.c_data_out;
            end
        end
    end
endmodule

// File: tb/tb_lobster_cache_arb.sv
// Bench for lobster_cache_arb: directed scenarios then random traffic, every cycle checked
// against a transaction-level model with a small direct-mapped cache standing in for the array.
module tb_lobster_cache_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lobster_cache_arb_if #(.ADDR_WIDTH(36), .DATA_WIDTH(64), .CNT_WIDTH(16)) bus ();

    lobster_cache_arb #(.ADDR_WIDTH(36), .DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Cache stand-in: 256 words, tag = full address, hit judged on addr_in.
    bit [35:0] cm_tag [256];
    bit [63:0] cm_dat [256];
    bit        cm_vld [256];

    always @(posedge clk) begin
        if (bus.c_we) begin
            cm_tag[bus.c_addr_in[10:3]] <= bus.c_addr_in;
            cm_dat[bus.c_addr_in[10:3]] <= bus.c_data_in;
            cm_vld[bus.c_addr_in[10:3]] <= 1'b1;
        end
        if (bus.c_inv && cm_tag[bus.c_addr_in[10:3]] == bus.c_addr_in) begin
            cm_vld[bus.c_addr_in[10:3]] <= 1'b0;
        end
    end

    assign bus.c_data_out = (cm_vld[bus.c_addr_in[10:3]] &&
                             cm_tag[bus.c_addr_in[10:3]] == bus.c_addr_in)
                            ? cm_dat[bus.c_addr_out[10:3]] : 64'd0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic [63:0] ref_mem [logic [35:0]];
    logic        m_last;       // 1: rq1 granted most recently
    logic        m_busy;       // invalidate occupies the current cycle
    int          m_left;       // sweep words still to issue
    logic [35:0] m_addr;
    int          m_done_due;
    logic        iss_v, iss_we, iss_id;
    logic [35:0] iss_addr;
    logic [63:0] iss_wd, iss_dat;
    logic        rsp_v, rsp_id;
    logic [63:0] rsp_dat;
    logic [63:0] m_rd0, m_rd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs after.
    task automatic tick();
        logic        av, e0, e1, take, acc, acc_id, a_we, rst_s;
        logic [35:0] a_addr, t_base;
        logic [63:0] a_wd;
        int          t_cnt;
        logic        ew, ei;
        logic [35:0] eai, eao;
        logic [63:0] edi;
        @(negedge clk);
        av = !rst && !bus.inv_start && !m_busy;
        e0 = av && bus.rq0_valid && (!bus.rq1_valid || m_last);
        e1 = av && bus.rq1_valid && (!bus.rq0_valid || !m_last);
        chk("rq0_ready", 64'(bus.rq0_ready), 64'(e0));
        chk("rq1_ready", 64'(bus.rq1_ready), 64'(e1));
        take   = !rst && bus.inv_start && !m_busy;
        acc    = e0 || e1;
        acc_id = e1;
        a_we   = e1 ? bus.rq1_we : bus.rq0_we;
        a_addr = e1 ? bus.rq1_addr : bus.rq0_addr;
        a_wd   = e1 ? bus.rq1_wdata : bus.rq0_wdata;
        t_base = bus.inv_base;
        t_cnt  = int'(bus.inv_count);
        rst_s  = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            m_last = 1'b1; m_left = 0; m_done_due = -1;
            iss_v = 1'b0; rsp_v = 1'b0; m_rd0 = '0; m_rd1 = '0;
        end else begin
            rsp_v   = iss_v && !iss_we;
            rsp_id  = iss_id;
            rsp_dat = iss_dat;
            iss_v   = acc;
            if (acc) begin
                iss_we = a_we; iss_id = acc_id; iss_addr = a_addr; iss_wd = a_wd;
                m_last = acc_id;
                if (a_we) ref_mem[a_addr] = a_wd;
                else iss_dat = (ref_mem.exists(a_addr) != 0) ? ref_mem[a_addr] : 64'd0;
            end
            if (rsp_v) begin
                if (rsp_id) m_rd1 = rsp_dat;
                else m_rd0 = rsp_dat;
            end
            if (take) begin
                m_left = t_cnt; m_addr = t_base; m_done_due = cyc + t_cnt;
            end
        end
        chk("rq0_rvalid", 64'(bus.rq0_rvalid), 64'(rsp_v && !rsp_id));
        chk("rq1_rvalid", 64'(bus.rq1_rvalid), 64'(rsp_v && rsp_id));
        chk("rq0_rdata", bus.rq0_rdata, m_rd0);
        chk("rq1_rdata", bus.rq1_rdata, m_rd1);
        ew = 1'b0; ei = 1'b0; eai = '0; eao = '0; edi = '0;
        if (iss_v) begin
            eai = iss_addr;
            if (iss_we) begin ew = 1'b1; edi = iss_wd; end
            else eao = iss_addr;
        end else if (m_left > 0) begin
            ei = 1'b1; eai = m_addr;
        end
        m_busy = (m_left > 0);
        chk("c_we", 64'(bus.c_we), 64'(ew));
        chk("c_inv", 64'(bus.c_inv), 64'(ei));
        chk("c_addr_in", 64'(bus.c_addr_in), 64'(eai));
        chk("c_addr_out", 64'(bus.c_addr_out), 64'(eao));
        chk("c_data_in", bus.c_data_in, edi);
        chk("inv_busy", 64'(bus.inv_busy), 64'(m_busy));
        chk("inv_done", 64'(bus.inv_done), 64'(cyc == m_done_due));
        if (m_left > 0) begin
            ref_mem.delete(m_addr);
            m_addr = m_addr + 36'd8;
            m_left--;
        end
    endtask

    task automatic req0(input logic v, input logic we, input logic [35:0] a, input logic [63:0] d);
        bus.rq0_valid = v; bus.rq0_we = we; bus.rq0_addr = a; bus.rq0_wdata = d;
    endtask

    task automatic req1(input logic v, input logic we, input logic [35:0] a, input logic [63:0] d);
        bus.rq1_valid = v; bus.rq1_we = we; bus.rq1_addr = a; bus.rq1_wdata = d;
    endtask

    task automatic inv(input logic s, input logic [35:0] base, input logic [15:0] cnt);
        bus.inv_start = s; bus.inv_base = base; bus.inv_count = cnt;
    endtask

    initial begin
        m_last = 1'b1; m_busy = 1'b0; m_left = 0; m_addr = '0; m_done_due = -1;
        iss_v = 1'b0; iss_we = 1'b0; iss_id = 1'b0; iss_addr = '0; iss_wd = '0; iss_dat = '0;
        rsp_v = 1'b0; rsp_id = 1'b0; rsp_dat = '0; m_rd0 = '0; m_rd1 = '0;
        rst = 1'b1;
        req0(1'b0, 1'b0, '0, '0);
        req1(1'b0, 1'b0, '0, '0);
        inv(1'b0, '0, '0);
        tick();
        tick();

        // 1: write then read back through rq0
        rst = 1'b0;
        req0(1'b1, 1'b1, 36'h0FFF80000, 64'h12345678);
        tick();
        req0(1'b0, 1'b0, '0, '0);
        tick();
        req0(1'b1, 1'b0, 36'h0FFF80000, '0);
        tick();
        req0(1'b0, 1'b0, '0, '0);
        tick();
        chk("t1_rvalid", 64'(bus.rq0_rvalid), 64'd1);
        chk("t1_rdata", bus.rq0_rdata, 64'h12345678);
        tick();

        // 2: both requesters contend for four cycles from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0(1'b1, 1'b0, 36'h2000, '0);
        req1(1'b1, 1'b0, 36'h2008, '0);
        repeat (4) tick();
        req0(1'b0, 1'b0, '0, '0);
        req1(1'b0, 1'b0, '0, '0);
        repeat (3) tick();

        // 3: range invalidate behind an in-flight read; a held read waits it out
        for (int i = 0; i < 3; i++) begin
            req0(1'b1, 1'b1, 36'h100 + 36'(8 * i), 64'hA000 + 64'(i));
            tick();
        end
        req0(1'b1, 1'b0, 36'h110, '0);
        tick();
        inv(1'b1, 36'h100, 16'd3);
        req0(1'b1, 1'b0, 36'h108, '0);
        tick();
        inv(1'b0, '0, '0);
        repeat (4) tick();
        req0(1'b0, 1'b0, '0, '0);
        repeat (3) tick();

        // 4: zero-length invalidate
        inv(1'b1, 36'h2000, 16'd0);
        tick();
        inv(1'b0, '0, '0);
        chk("t4_done", 64'(bus.inv_done), 64'd1);
        repeat (2) tick();

        // 5: sweep wrapping at the top of the address space
        inv(1'b1, 36'hFFFFFFFF8, 16'd2);
        tick();
        inv(1'b0, '0, '0);
        chk("t5_addr0", 64'(bus.c_addr_in), 64'h0FFFFFFFF8);
        tick();
        chk("t5_addr1", 64'(bus.c_addr_in), 64'd0);
        chk("t5_inv1", 64'(bus.c_inv), 64'd1);
        repeat (2) tick();

        // 6: reset during the second sweep cycle
        inv(1'b1, 36'h2000, 16'd5);
        tick();
        inv(1'b0, '0, '0);
        tick();
        rst = 1'b1;
        req0(1'b1, 1'b1, 36'h2008, 64'h5A5A);
        tick();
        rst = 1'b0;
        tick();
        req0(1'b0, 1'b0, '0, '0);
        repeat (6) tick();

        // Random traffic with occasional invalidates
        for (int i = 0; i < 400; i++) begin
            req0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 36'h2000 + 36'(8 * $urandom_range(0, 31)), {$urandom, $urandom});
            req1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 36'h2000 + 36'(8 * $urandom_range(0, 31)), {$urandom, $urandom});
            inv(($urandom_range(0, 15) == 0), 36'h2000 + 36'(8 * $urandom_range(0, 31)),
                16'($urandom_range(0, 4)));
            tick();
        end
        req0(1'b0, 1'b0, '0, '0);
        req1(1'b0, 1'b0, '0, '0);
        inv(1'b0, '0, '0);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lobster_cache_arb.md
Name: lobster_cache_arb

Overview:
- Front-end controller for the lobster_cache data array.
- Arbitrates two requesters onto the cache's single write/invalidate port and single read port. Typical pairing: requester 0 = fetch, requester 1 = load/store.
- Sequences multi-word range invalidations, one word per cycle.
- Owns every cache-side control signal. Nothing else drives the cache.

Parameters:
- ADDR_WIDTH, 36, address width, matching the cache.
- DATA_WIDTH, 64, data word width, matching the cache.
- CNT_WIDTH, 16, width of the range-invalidate word count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rq0_valid / rq1_valid  in  1  request present
- rq0_ready / rq1_ready  out  1  request accepted at this posedge if valid
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_WIDTH  request address
- rq0_wdata / rq1_wdata  in  DATA_WIDTH  write data
- rq0_rvalid / rq1_rvalid  out  1  one-cycle read-response pulse
- rq0_rdata / rq1_rdata  out  DATA_WIDTH  read data, held until next response to that requester
- inv_start  in  1  range-invalidate request pulse
- inv_base  in  ADDR_WIDTH  first byte address of the range
- inv_count  in  CNT_WIDTH  number of words to invalidate
- inv_busy  out  1  invalidate pending or sweeping
- inv_done  out  1  one-cycle completion pulse
- c_we, c_inv  out  1  to cache we / inv
- c_addr_in, c_addr_out  out  ADDR_WIDTH  to cache addr_in / addr_out
- c_data_in  out  DATA_WIDTH  to cache data_in
- c_data_out  in  DATA_WIDTH  from cache data_out (combinational)

Behaviour:
- Reset: state IDLE; issue register empty; pending flag clear; round-robin pointer favours rq0. All outputs 0, including ready, rvalid, rdata, c_*, inv_busy, inv_done. A reset mid-sweep abandons the sweep and produces no inv_done.
- States: IDLE, SWEEP.
- Pending flag: set when inv_start is seen in IDLE.
- Grant, IDLE only, pending clear, inv_start low:
  - One valid requester: it is granted.
  - Both valid: grant the one not last granted.
  - rqX_ready = grantX. The pointer updates only on acceptance. At most one acceptance per cycle.
- inv_start wins over requests in the same cycle: both ready signals are low that cycle. inv_start is ignored while inv_busy = 1.
- Issue stage: the accepted request is registered at edge N and drives the cache during cycle N+1.
  - Write: c_we = 1, c_addr_in = addr, c_data_in = wdata.
  - Read: c_addr_out = addr and c_addr_in = addr (the cache validity lookup uses addr_in). c_data_out is captured at edge N+1. rqX_rvalid = 1 and rqX_rdata are valid in cycle N+2. Read latency is 2 cycles after acceptance.
  - Throughput: one operation per cycle, back-to-back.
  - A write at N+1 is visible to a read accepted at edge N+1 or later.
- When no operation is issuing, all c_* outputs are 0.
- Pending to SWEEP:
  - inv_base/inv_count are captured when inv_start is seen.
  - SWEEP begins on the first cycle with the issue register empty, i.e. after any in-flight operation drains.
  - inv_count = 0: no sweep; inv_done pulses the cycle after inv_start.
- SWEEP:
  - Each cycle: c_inv = 1, c_addr_in = cur.
  - cur += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
  - remaining decrements each cycle.
  - When the last word is issued (remaining = 1): return to IDLE; inv_done pulses the next cycle; pending clears.
- inv_busy = pending OR SWEEP.
- No requests are accepted while inv_busy = 1.

Test Plan:
1. Reset, then rq0 write addr 0xFFF80000 data 0x12345678, then rq0 read same addr. Required: c_we pulses one cycle after write acceptance; rq0_rvalid 2 cycles after read acceptance with rq0_rdata = 0x12345678.
2. rq0 and rq1 both hold valid reads for 4 cycles. Required: grants alternate rq0, rq1, rq0, rq1; each rvalid pulses exactly 2 cycles after its acceptance.
3. inv_start with base 0x100, count 3, while a read is in flight. Required: that read completes; c_inv pulses with c_addr_in = 0x100, 0x108, 0x110 on consecutive cycles; inv_done one cycle later; ready is 0 throughout; a subsequent read of 0x108 returns 0.
4. inv_start with count 0. Required: inv_done pulses the next cycle; no c_inv pulse.
5. Sweep with base = 2^36 − 8, count 2. Required: c_addr_in = 0xFFFFFFFF8, then 0x000000000.
6. rst asserted on the second sweep cycle. Required: all outputs 0 the next cycle; no inv_done; rq0 request accepted in the first cycle after rst deasserts.
